// File: rtl/en_reg_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : en_reg_bank_if
// Description : Bundle of the data, control and status signals of en_reg_bank.
//               master modport : producer side (drives d/en/freeze/clr_stat)
//               slave modport  : the register bank itself
//               Signals:
//                 d          NUM_CH*WIDTH  channel data, ch i = d[i*WIDTH +: WIDTH]
//                 en         NUM_CH        per-channel load enable
//                 freeze     1             global hold, blocks every load
//                 clr_stat   1             clears all sticky_chg bits
//                 q          NUM_CH*WIDTH  held channel values
//                 chg        NUM_CH        one-cycle "value changed" pulse
//                 sticky_chg NUM_CH        sticky change flags
//                 stable_cnt NUM_CH*CNT_W  saturating cycles-since-change
//                 q_prev     NUM_CH*WIDTH  previous value (EN_REG_BANK_PREV_EN only)
// Option      : EN_REG_BANK_PREV_EN adds the q_prev signal.
// Revision    : 1.0 - initial release
// ============================================================================
interface en_reg_bank_if #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 8,
   parameter int CNT_W  = 4
);
   logic [NUM_CH*WIDTH-1:0] d;
   logic [NUM_CH-1:0]       en;
   logic                    freeze;
   logic                    clr_stat;
   logic [NUM_CH*WIDTH-1:0] q;
   logic [NUM_CH-1:0]       chg;
   logic [NUM_CH-1:0]       sticky_chg;
   logic [NUM_CH*CNT_W-1:0] stable_cnt;
`ifdef EN_REG_BANK_PREV_EN
   logic [NUM_CH*WIDTH-1:0] q_prev;
`endif

   modport master (
      output d, en, freeze, clr_stat,
      input  q, chg, sticky_chg, stable_cnt
`ifdef EN_REG_BANK_PREV_EN
      , input q_prev
`endif
   );

   modport slave (
      input  d, en, freeze, clr_stat,
      output q, chg, sticky_chg, stable_cnt
`ifdef EN_REG_BANK_PREV_EN
      , output q_prev
`endif
   );
endinterface
`default_nettype wire

// File: rtl/en_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : en_reg_bank
// Description : NUM_CH independent WIDTH-bit clocked storage channels with a
//               global freeze, per-channel change pulse, sticky change status
//               and a saturating stability counter. All outputs are flops.
//               Ports:
//                 clk   rising-edge clock
//                 rstn  synchronous active-low reset
//                 bus   en_reg_bank_if.slave (d, en, freeze, clr_stat in;
//                       q, chg, sticky_chg, stable_cnt [, q_prev] out)
// Option      : EN_REG_BANK_PREV_EN - keep the value each channel held before
//               its most recent differing load (q_prev).
// Revision    : 1.0 - initial release
// ============================================================================
module en_reg_bank #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 8,
   parameter int CNT_W  = 4
) (
   input  wire logic     clk,
   input  wire logic     rstn,
   en_reg_bank_if.slave  bus
);

   localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

   logic [NUM_CH*WIDTH-1:0] w_q_flat;
   logic [NUM_CH-1:0]       w_chg_flat;
   logic [NUM_CH-1:0]       w_sticky_flat;
   logic [NUM_CH*CNT_W-1:0] w_cnt_flat;
`ifdef EN_REG_BANK_PREV_EN
   logic [NUM_CH*WIDTH-1:0] w_prev_flat;
`endif

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [WIDTH-1:0] data_d,   data_q;
      logic             chg_d,    chg_q;
      logic             sticky_d, sticky_q;
      logic [CNT_W-1:0] cnt_d,    cnt_q;
      logic [WIDTH-1:0] d_ch;
      logic             ld;
      logic             diff;

      assign d_ch = bus.d[i*WIDTH +: WIDTH];

      always_comb begin
         ld       = 1'b0;
         diff     = 1'b0;
         data_d   = data_q;
         chg_d    = 1'b0;
         sticky_d = sticky_q;
         cnt_d    = cnt_q;

         ld   = bus.en[i] & ~bus.freeze;
         // Only a load that actually changes the stored value counts as an event;
         // an equal-value reload is invisible to the status logic.
         diff = ld && (d_ch != data_q);

         if (ld) begin
            data_d = d_ch;
         end
         chg_d = diff;

         // Set has priority over clear so a change coinciding with clr_stat is kept.
         if (diff) begin
            sticky_d = 1'b1;
         end else if (bus.clr_stat) begin
            sticky_d = 1'b0;
         end

         if (diff) begin
            cnt_d = '0;
         end else if (cnt_q != C_CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (!rstn) begin
            data_q   <= '0;
            chg_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
         end else begin
            data_q   <= data_d;
            chg_q    <= chg_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
         end
      end

      assign w_q_flat[i*WIDTH +: WIDTH] = data_q;
      assign w_chg_flat[i]              = chg_q;
      assign w_sticky_flat[i]           = sticky_q;
      assign w_cnt_flat[i*CNT_W +: CNT_W] = cnt_q;

`ifdef EN_REG_BANK_PREV_EN
      logic [WIDTH-1:0] prev_d, prev_q;

      always_comb begin
         prev_d = prev_q;
         if (diff) begin
            prev_d = data_q;
         end
      end

      always_ff @(posedge clk) begin
         if (!rstn) begin
            prev_q <= '0;
         end else begin
            prev_q <= prev_d;
         end
      end

      assign w_prev_flat[i*WIDTH +: WIDTH] = prev_q;
`endif
   end : g_ch

   assign bus.q          = w_q_flat;
   assign bus.chg        = w_chg_flat;
   assign bus.sticky_chg = w_sticky_flat;
   assign bus.stable_cnt = w_cnt_flat;
`ifdef EN_REG_BANK_PREV_EN
   assign bus.q_prev     = w_prev_flat;
`endif

endmodule
`default_nettype wire
